// File: rtl/constant_sequence_checker.sv
// Lockstep checker for a three-field stream against a fixed three-step expected
// sequence (last step repeats); reports done/pass/fail, first failing step and error count.
module constant_sequence_checker #(
  parameter logic [31:0] EXP0_A   = 32'd0,
  parameter logic        EXP0_B   = 1'b0,
  parameter logic [3:0]  EXP0_C   = 4'd1,
  parameter logic [31:0] EXP1_A   = 32'd1,
  parameter logic        EXP1_B   = 1'b1,
  parameter logic [3:0]  EXP1_C   = 4'd1,
  parameter logic [31:0] EXP2_A   = 32'd15,
  parameter logic        EXP2_B   = 1'b1,
  parameter logic [3:0]  EXP2_C   = 4'd9,
  parameter int unsigned HOLD_MIN = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in1,
  input  logic             in2,
  input  logic [3:0]       in3,
  output logic [1:0]       state_out,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       err_step,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(HOLD_MIN);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [1:0] {
    ST_EXP0 = 2'd0,
    ST_EXP1 = 2'd1,
    ST_EXP2 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic [1:0]         err_step_q, err_step_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [31:0]        exp_a_c;
  logic               exp_b_c;
  logic [3:0]         exp_c_c;
  logic               mismatch_c;

  // Expected fields for the current step
  always_comb begin
    exp_a_c = EXP2_A;
    exp_b_c = EXP2_B;
    exp_c_c = EXP2_C;
    case (state_q)
      ST_EXP0: begin
        exp_a_c = EXP0_A;
        exp_b_c = EXP0_B;
        exp_c_c = EXP0_C;
      end
      ST_EXP1: begin
        exp_a_c = EXP1_A;
        exp_b_c = EXP1_B;
        exp_c_c = EXP1_C;
      end
      default: ;
    endcase
    mismatch_c = (in1 != exp_a_c) || (in2 != exp_b_c) || (in3 != exp_c_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EXP0;
      hold_cnt_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_step_q  <= 2'd0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_step_q  <= err_step_d;
      err_count_q <= err_count_d;
    end
  end

  // State advances on every sample regardless of match to keep lockstep
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    fail_d      = fail_q;
    err_step_d  = err_step_q;
    err_count_d = err_count_q;
    if (in_valid) begin
      case (state_q)
        ST_EXP0: state_d = ST_EXP1;
        ST_EXP1: state_d = ST_EXP2;
        default: state_d = ST_EXP2;
      endcase
      if (state_q == ST_EXP2 && hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      if (mismatch_c) begin
        fail_d = 1'b1;
        if (!fail_q) begin
          err_step_d = state_q;
        end
        if (err_count_q != ERR_MAX) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
      end
    end
    done_d = done_q || (hold_cnt_d >= HOLD_TGT);
    pass_d = done_d && !fail_d;
  end

  assign state_out = state_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_step  = err_step_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_constant_sequence_checker.sv
// Scoreboard bench: a reference model pushes expected outputs per driven cycle,
// popped and compared against a default checker and an ERR_W=2 checker.
module tb_constant_sequence_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in1;
  logic        in2;
  logic [3:0]  in3;

  logic [1:0]  state_out, err_step;
  logic        done, pass, fail;
  logic [7:0]  err_count;

  logic [1:0]  state_out2, err_step2;
  logic        done2, pass2, fail2;
  logic [1:0]  err_count2;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       done;
    logic       pass;
    logic       fail;
    logic [1:0] step;
    logic [7:0] e8;
    logic [1:0] e2;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [1:0] m_state;
  int         m_hold;
  logic       m_done, m_pass, m_fail;
  logic [1:0] m_step;
  int         m_e8, m_e2;

  always #5 clk = ~clk;

  constant_sequence_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3),
    .state_out(state_out), .done(done), .pass(pass), .fail(fail),
    .err_step(err_step), .err_count(err_count)
  );

  constant_sequence_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3),
    .state_out(state_out2), .done(done2), .pass(pass2), .fail(fail2),
    .err_step(err_step2), .err_count(err_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [31:0] a,
                            input logic b, input logic [3:0] c);
    logic [31:0] ea;
    logic        eb;
    logic [3:0]  ec;
    exp_t        e;
    if (rst) begin
      m_state = 0; m_hold = 0; m_done = 0; m_fail = 0; m_step = 0; m_e8 = 0; m_e2 = 0;
    end else if (v) begin
      case (m_state)
        2'd0:    begin ea = 0;  eb = 0; ec = 1; end
        2'd1:    begin ea = 1;  eb = 1; ec = 1; end
        default: begin ea = 15; eb = 1; ec = 9; end
      endcase
      if (m_state == 2 && m_hold < 255) m_hold++;
      if (a != ea || b != eb || c != ec) begin
        if (!m_fail) m_step = m_state;
        m_fail = 1;
        if (m_e8 < 255) m_e8++;
        if (m_e2 < 3) m_e2++;
      end
      if (m_state != 2) m_state = m_state + 2'd1;
      if (m_hold >= 4) m_done = 1;
    end
    m_pass = m_done & ~m_fail;
    e.st = m_state; e.done = m_done; e.pass = m_pass; e.fail = m_fail;
    e.step = m_step; e.e8 = 8'(m_e8); e.e2 = 2'(m_e2);
    sb.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [31:0] a,
                       input logic b, input logic [3:0] c);
    exp_t e;
    reset = rst; in_valid = v; in1 = a; in2 = b; in3 = c;
    model_step(rst, v, a, b, c);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("state_out", 32'(state_out), 32'(e.st));
      check_eq("done",      32'(done),      32'(e.done));
      check_eq("pass",      32'(pass),      32'(e.pass));
      check_eq("fail",      32'(fail),      32'(e.fail));
      check_eq("err_step",  32'(err_step),  32'(e.step));
      check_eq("err_count", 32'(err_count), 32'(e.e8));
      check_eq("err_count_w2", 32'(err_count2), 32'(e.e2));
      check_eq("pass_w2",   32'(pass2),     32'(e.pass));
    end
  endtask

  task automatic golden_sample(input int k);
    case (k)
      0:       cycle(0, 1, 32'd0, 1'b0, 4'd0 + 4'd1);
      1:       cycle(0, 1, 32'd1, 1'b1, 4'd1);
      default: cycle(0, 1, 32'd15, 1'b1, 4'd9);
    endcase
  endtask

  task automatic do_reset();
    cycle(1, 0, 32'd0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1; in_valid = 0; in1 = 0; in2 = 0; in3 = 0;

    // reset state, including a sample concurrent with reset
    do_reset();
    cycle(1, 1, 32'd7, 1'b0, 4'd0);

    // golden run, then a late error after done
    for (int k = 0; k < 6; k++) golden_sample(k);
    golden_sample(6);
    cycle(0, 1, 32'd15, 1'b1, 4'd8);
    golden_sample(7);

    // step-1 corruption
    do_reset();
    golden_sample(0);
    cycle(0, 1, 32'd2, 1'b1, 4'd1);
    for (int k = 2; k < 6; k++) golden_sample(k);

    // valid gaps on alternate cycles
    do_reset();
    for (int k = 0; k < 6; k++) begin
      golden_sample(k);
      cycle(0, 0, 32'd99, 1'b0, 4'd3);
    end

    // reset mid-run, then full golden replay
    do_reset();
    golden_sample(0);
    golden_sample(1);
    do_reset();
    for (int k = 0; k < 6; k++) golden_sample(k);

    // all-wrong samples: saturation on the narrow counter
    do_reset();
    for (int k = 0; k < 6; k++) cycle(0, 1, 32'd7, (k == 0) ? 1'b0 : 1'b1, (k < 2) ? 4'd1 : 4'd9);
    check_eq("w2_done", 32'(done2), 32'd1);
    check_eq("w2_err_step", 32'(err_step2), 32'd0);

    // randomized stream mixing valid gaps and occasional corruption
    do_reset();
    for (int k = 0; k < 40; k++) begin
      logic v;
      logic bad;
      v   = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      case (m_state)
        2'd0:    cycle(0, v, bad ? 32'd5 : 32'd0, 1'b0, 4'd1);
        2'd1:    cycle(0, v, 32'd1, 1'b1, bad ? 4'd2 : 4'd1);
        default: cycle(0, v, 32'd15, bad ? 1'b0 : 1'b1, 4'd9);
      endcase
    end

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
